// File: rtl/pdp8_pkg.sv
// Shared types for the PDP-8 front-panel control slice.
package pdp8_pkg;

  typedef enum logic [1:0] {
    RS_IDLE      = 2'd0,
    RS_RUN       = 2'd1,
    RS_HALT_PEND = 2'd2,
    RS_STEP      = 2'd3
  } run_state_t;

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchroniser plus stability-counter debouncer for one panel switch.
// PRESS is a registered one-cycle pulse on each accepted rising level.
module switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic CLK,
  input  logic RESET,
  input  logic RAW,
  output logic LEVEL,
  output logic PRESS
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_dly_q;
  logic          press_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // The level flips on the edge the counter would reach DEBOUNCE_CYCLES.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= RAW;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;
    end
  end

  assign LEVEL = level_q;
  assign PRESS = press_q;

endmodule

// File: rtl/run_halt_ctrl.sv
// Front-panel run/halt controller: debounced switches drive a run-state FSM that
// stops the sequencer only at instruction boundaries, and counts completed instructions.
module run_halt_ctrl
  import pdp8_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SW_RUN,
  input  logic             SW_HALT,
  input  logic             SW_SSTEP,
  input  logic             INSTR_DONE,
  input  logic             HLT_INSTR,
  output logic             RUN_OUT,
  output logic             HALT_OUT,
  output logic             RUN_LED,
  output logic [CNT_W-1:0] INSTR_CNT
);

  logic [2:0]       sw_level_unused;
  logic             run_press, halt_press, step_press;

  run_state_t       state_q, state_d;
  logic             run_q, halt_q, halt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .CLK(CLK), .RESET(RESET), .RAW(SW_RUN), .LEVEL(sw_level_unused[0]), .PRESS(run_press)
  );

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_halt_db (
    .CLK(CLK), .RESET(RESET), .RAW(SW_HALT), .LEVEL(sw_level_unused[1]), .PRESS(halt_press)
  );

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .CLK(CLK), .RESET(RESET), .RAW(SW_SSTEP), .LEVEL(sw_level_unused[2]), .PRESS(step_press)
  );

  always_comb begin
    state_d = state_q;
    halt_d  = 1'b0;
    case (state_q)
      RS_IDLE: begin
        // HALT wins over a simultaneous RUN/SSTEP press.
        if (halt_press) begin
          state_d = RS_IDLE;
        end else if (step_press) begin
          state_d = RS_STEP;
        end else if (run_press) begin
          state_d = RS_RUN;
        end
      end
      RS_RUN: begin
        if (halt_press || HLT_INSTR) begin
          if (INSTR_DONE) begin
            state_d = RS_IDLE;
            halt_d  = 1'b1;
          end else begin
            state_d = RS_HALT_PEND;
          end
        end
      end
      RS_HALT_PEND, RS_STEP: begin
        if (INSTR_DONE) begin
          state_d = RS_IDLE;
          halt_d  = 1'b1;
        end
      end
      default: state_d = RS_IDLE;
    endcase
  end

  assign cnt_d = (INSTR_DONE && (state_q != RS_IDLE)) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= RS_IDLE;
      run_q   <= 1'b0;
      halt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= (state_d != RS_IDLE);
      halt_q  <= halt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign RUN_OUT   = run_q;
  assign RUN_LED   = run_q;
  assign HALT_OUT  = halt_q;
  assign INSTR_CNT = cnt_q;

endmodule

// File: tb/tb_run_halt_ctrl.sv
// Directed + randomized bench for run_halt_ctrl with DEBOUNCE_CYCLES=4.
module tb_run_halt_ctrl;

  localparam int D  = 4;
  localparam int CW = 16;

  logic          CLK, RESET;
  logic          SW_RUN, SW_HALT, SW_SSTEP, INSTR_DONE, HLT_INSTR;
  logic          RUN_OUT, HALT_OUT, RUN_LED;
  logic [CW-1:0] INSTR_CNT;

  int            checks   = 0;
  int            failures = 0;
  int            edge_n   = 0;
  logic [CW-1:0] exp_cnt;
  logic          d;

  run_halt_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(CW)) u_dut (
    .CLK(CLK), .RESET(RESET),
    .SW_RUN(SW_RUN), .SW_HALT(SW_HALT), .SW_SSTEP(SW_SSTEP),
    .INSTR_DONE(INSTR_DONE), .HLT_INSTR(HLT_INSTR),
    .RUN_OUT(RUN_OUT), .HALT_OUT(HALT_OUT), .RUN_LED(RUN_LED),
    .INSTR_CNT(INSTR_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) edge_n <= edge_n + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Hold a switch long enough to debounce, then release and let the release settle.
  task automatic press_sw(input int which);
    if (which == 0) SW_RUN = 1'b1;
    else if (which == 1) SW_HALT = 1'b1;
    else SW_SSTEP = 1'b1;
    cyc(12);
    SW_RUN = 1'b0; SW_HALT = 1'b0; SW_SSTEP = 1'b0;
    cyc(10);
  endtask

  initial begin
    RESET = 1'b1; SW_RUN = 1'b0; SW_HALT = 1'b0; SW_SSTEP = 1'b0;
    INSTR_DONE = 1'b0; HLT_INSTR = 1'b0;
    exp_cnt = '0;
    cyc(2);
    RESET = 1'b0;
    chk("reset_run_out", RUN_OUT, 0);
    chk("reset_halt_out", HALT_OUT, 0);
    chk("reset_run_led", RUN_LED, 0);
    chk("reset_cnt", INSTR_CNT, 0);

    // Switch first sampled at edge 10 -> RUN visible after edge 17.
    while (edge_n < 9) @(negedge CLK);
    SW_RUN = 1'b1;
    while (edge_n < 16) @(negedge CLK);
    chk("t1_run_before_e17", RUN_OUT, 0);
    @(negedge CLK);
    chk("t1_run_after_e17", RUN_OUT, 1);
    chk("t1_led_after_e17", RUN_LED, 1);
    chk("t1_cnt", INSTR_CNT, 0);
    SW_RUN = 1'b0;
    cyc(10);
    chk("t1_release_ignored", RUN_OUT, 1);

    // Random instruction completions while running.
    for (int i = 0; i < 40; i++) begin
      chk("rand_cnt", INSTR_CNT, exp_cnt);
      chk("rand_run", RUN_OUT, 1);
      chk("rand_no_halt", HALT_OUT, 0);
      d = 1'($urandom_range(0, 1));
      INSTR_DONE = d;
      if (d) exp_cnt = exp_cnt + 1'b1;
      @(negedge CLK);
    end
    INSTR_DONE = 1'b0;
    cyc(1);
    chk("rand_cnt_final", INSTR_CNT, exp_cnt);

    // Halt press while running waits for the instruction boundary.
    press_sw(1);
    for (int i = 0; i < 5; i++) begin
      chk("t3_run_wait", RUN_OUT, 1);
      chk("t3_halt_wait", HALT_OUT, 0);
      @(negedge CLK);
    end
    INSTR_DONE = 1'b1;
    exp_cnt = exp_cnt + 1'b1;
    @(negedge CLK);
    INSTR_DONE = 1'b0;
    chk("t3_halt_pulse", HALT_OUT, 1);
    chk("t3_run_low", RUN_OUT, 0);
    chk("t3_cnt", INSTR_CNT, exp_cnt);
    @(negedge CLK);
    chk("t3_halt_single", HALT_OUT, 0);

    // Single step from a fresh reset; halt press mid-step must not cut it short.
    RESET = 1'b1;
    cyc(1);
    RESET = 1'b0;
    exp_cnt = '0;
    press_sw(2);
    chk("t4_step_run", RUN_OUT, 1);
    press_sw(1);
    chk("t4_halt_no_abort", RUN_OUT, 1);
    chk("t4_no_early_halt", HALT_OUT, 0);
    INSTR_DONE = 1'b1;
    exp_cnt = exp_cnt + 1'b1;
    @(negedge CLK);
    INSTR_DONE = 1'b0;
    chk("t4_halt_pulse", HALT_OUT, 1);
    chk("t4_run_low", RUN_OUT, 0);
    chk("t4_cnt_one", INSTR_CNT, 1);
    @(negedge CLK);
    chk("t4_halt_single", HALT_OUT, 0);
    INSTR_DONE = 1'b1; HLT_INSTR = 1'b1;
    cyc(3);
    INSTR_DONE = 1'b0; HLT_INSTR = 1'b0;
    cyc(1);
    chk("t4_idle_cnt_hold", INSTR_CNT, exp_cnt);
    chk("t4_idle_stays", RUN_OUT, 0);

    // Run up to all-ones, then HLT with DONE in the same cycle wraps the count.
    press_sw(0);
    chk("t5_running", RUN_OUT, 1);
    while (exp_cnt != {CW{1'b1}}) begin
      INSTR_DONE = 1'b1;
      exp_cnt = exp_cnt + 1'b1;
      @(negedge CLK);
    end
    INSTR_DONE = 1'b0;
    @(negedge CLK);
    chk("t5_cnt_max", INSTR_CNT, 32'h0000_FFFF);
    chk("t5_still_run", RUN_OUT, 1);
    INSTR_DONE = 1'b1; HLT_INSTR = 1'b1;
    exp_cnt = exp_cnt + 1'b1;
    @(negedge CLK);
    INSTR_DONE = 1'b0; HLT_INSTR = 1'b0;
    chk("t5_halt_pulse", HALT_OUT, 1);
    chk("t5_run_low", RUN_OUT, 0);
    chk("t5_cnt_wrap", INSTR_CNT, 0);
    chk("t5_cnt_model", INSTR_CNT, exp_cnt);
    @(negedge CLK);
    chk("t5_halt_single", HALT_OUT, 0);

    // Reset while waiting for a boundary: straight to idle, no halt pulse.
    press_sw(0);
    press_sw(1);
    chk("t6_pend_run", RUN_OUT, 1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    exp_cnt = '0;
    chk("t6_rst_run", RUN_OUT, 0);
    chk("t6_rst_halt", HALT_OUT, 0);
    chk("t6_rst_cnt", INSTR_CNT, exp_cnt);
    @(negedge CLK);
    chk("t6_rst_no_pulse", HALT_OUT, 0);

    // RUN and HALT pressed together in idle.
    SW_RUN = 1'b1; SW_HALT = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      chk("t6_both_idle", RUN_OUT, 0);
    end
    SW_RUN = 1'b0; SW_HALT = 1'b0;
    cyc(10);

    // A glitch shorter than the debounce window is rejected.
    SW_RUN = 1'b1;
    cyc(3);
    SW_RUN = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      chk("t2_glitch_run", RUN_OUT, 0);
    end
    chk("t2_db_cnt_zero", 32'(u_dut.u_run_db.cnt_q), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
